// File: rtl/ctrl_pkg.sv
// Shared encodings for the control sequencer: opcodes, FSM states,
// instruction classes and the strobe bundles driven onto the datapath.
package ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,  OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4,  OP_AND  = 5'd5,  OP_OR   = 5'd6,  OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHRA = 5'd8,  OP_SHL  = 5'd9,  OP_ROR  = 5'd10, OP_ROL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14, OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16, OP_NEG  = 5'd17, OP_NOT  = 5'd18, OP_BR   = 5'd19;
    localparam logic [4:0] OP_JR   = 5'd20, OP_JAL  = 5'd21, OP_IN   = 5'd22, OP_OUT  = 5'd23;
    localparam logic [4:0] OP_NOP  = 5'd26, OP_HALT = 5'd27;

    typedef enum logic [3:0] {
        S_F0 = 4'd0, S_F1 = 4'd1, S_F2 = 4'd2, S_F3 = 4'd3,
        S_E0 = 4'd4, S_E1 = 4'd5, S_E2 = 4'd6, S_E3 = 4'd7, S_E4 = 4'd8, S_E5 = 4'd9,
        S_DIV_WAIT = 4'd10, S_HALT = 4'd11
    } state_t;

    typedef enum logic [3:0] {
        CL_NOP = 4'd0, CL_HALT = 4'd1, CL_LD = 4'd2, CL_LDI = 4'd3, CL_ST = 4'd4,
        CL_RTYPE = 4'd5, CL_IMM = 4'd6, CL_UNARY = 4'd7, CL_MUL = 4'd8, CL_DIV = 4'd9,
        CL_BR = 4'd10, CL_JR = 4'd11, CL_JAL = 4'd12, CL_IN = 4'd13, CL_OUT = 4'd14
    } class_t;

    typedef struct packed {
        logic and_op, or_op, add_op, sub_op, mul_op, div_op, shr_op;
        logic shl_op, ror_op, rol_op, neg_op, not_op, shra_op;
    } alu_t;

    localparam alu_t ALU_ADD = 13'b0010000000000;

    typedef struct packed {
        logic pc_out, mdr_out, zhigh_out, zlow_out, hi_in, lo_in, mdr_in, mar_in, z_in;
        logic y_in, ir_in, pc_in, read, write, inc_pc, ba_out, inport_out, outport_in;
        logic gra, grb, grc, r_in, r_out, c_out, con_in, div_rst;
    } strobe_t;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode decoder: instruction class, the ALU operation the opcode names,
// and an illegal flag for unassigned opcodes (which are treated as nop).
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output class_t     cls,
    output alu_t       alu_op,
    output logic       illegal
);

    // Opcode to class / ALU-op lookup
    always_comb begin
        cls     = CL_NOP;
        alu_op  = '0;
        illegal = 1'b0;
        case (opcode)
            OP_LD:   cls = CL_LD;
            OP_LDI:  cls = CL_LDI;
            OP_ST:   cls = CL_ST;
            OP_ADD:  begin cls = CL_RTYPE; alu_op.add_op  = 1'b1; end
            OP_SUB:  begin cls = CL_RTYPE; alu_op.sub_op  = 1'b1; end
            OP_AND:  begin cls = CL_RTYPE; alu_op.and_op  = 1'b1; end
            OP_OR:   begin cls = CL_RTYPE; alu_op.or_op   = 1'b1; end
            OP_SHR:  begin cls = CL_RTYPE; alu_op.shr_op  = 1'b1; end
            OP_SHRA: begin cls = CL_RTYPE; alu_op.shra_op = 1'b1; end
            OP_SHL:  begin cls = CL_RTYPE; alu_op.shl_op  = 1'b1; end
            OP_ROR:  begin cls = CL_RTYPE; alu_op.ror_op  = 1'b1; end
            OP_ROL:  begin cls = CL_RTYPE; alu_op.rol_op  = 1'b1; end
            OP_ADDI: begin cls = CL_IMM;   alu_op.add_op  = 1'b1; end
            OP_ANDI: begin cls = CL_IMM;   alu_op.and_op  = 1'b1; end
            OP_ORI:  begin cls = CL_IMM;   alu_op.or_op   = 1'b1; end
            OP_MUL:  begin cls = CL_MUL;   alu_op.mul_op  = 1'b1; end
            OP_DIV:  begin cls = CL_DIV;   alu_op.div_op  = 1'b1; end
            OP_NEG:  begin cls = CL_UNARY; alu_op.neg_op  = 1'b1; end
            OP_NOT:  begin cls = CL_UNARY; alu_op.not_op  = 1'b1; end
            OP_BR:   cls = CL_BR;
            OP_JR:   cls = CL_JR;
            OP_JAL:  cls = CL_JAL;
            OP_IN:   cls = CL_IN;
            OP_OUT:  cls = CL_OUT;
            OP_NOP:  cls = CL_NOP;
            OP_HALT: cls = CL_HALT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: the FSM state plus the current opcode
// select every datapath strobe; divides are bounded by a timeout.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int RD_LAT      = 1,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IRdataout,
    input  logic        div_done,
    input  logic        stop,
    output logic PCout, MDRout, Zhighout, Zlowout, HIin, LOin, MDRin, MARin, Zin,
    output logic Yin, IRin, PCin, Read, Write, IncPC, BAout, InPortout, OutPortin,
    output logic Gra, Grb, Grc, Rin, Rout, Cout, CONin, div_rst,
    output logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, SHRA,
    output logic run,
    output logic fault
);

    localparam int CNT_W = $clog2(DIV_TIMEOUT + 4);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d, nxt_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d, fault_q, fault_d, last_s, illegal_s;
    class_t           cls_s;
    alu_t             dec_alu_s, alu_s;
    strobe_t          ctl_s;
    logic             ir_unused_s;

    // Only the opcode field steers sequencing; operand fields belong to the datapath.
    assign ir_unused_s = ^IRdataout[26:0];

    ctrl_decode u_decode (
        .opcode  (IRdataout[31:27]),
        .cls     (cls_s),
        .alu_op  (dec_alu_s),
        .illegal (illegal_s)
    );

    // Next state; last_s marks the final execute cycle where stop is honoured
    always_comb begin
        nxt_s   = S_F0;
        last_s  = 1'b0;
        cnt_d   = '0;
        fault_d = fault_q;
        case (state_q)
            S_F0: nxt_s = (RD_LAT == 0) ? S_F2 : S_F1;
            S_F1: begin
                nxt_s = (cnt_q == RD_LAST) ? S_F2 : S_F1;
                cnt_d = (cnt_q == RD_LAST) ? '0 : cnt_q + CNT_ONE;
            end
            S_F2: nxt_s = S_F3;
            S_F3: case (cls_s)
                CL_HALT: nxt_s = S_HALT;
                CL_NOP:  begin last_s = 1'b1; fault_d = fault_q | illegal_s; end
                default: nxt_s = S_E0;
            endcase
            S_E0: case (cls_s)
                CL_JR, CL_IN, CL_OUT: last_s = 1'b1;
                CL_DIV:  nxt_s = S_DIV_WAIT;
                default: nxt_s = S_E1;
            endcase
            S_E1: case (cls_s)
                CL_UNARY, CL_JAL: last_s = 1'b1;
                default: nxt_s = S_E2;
            endcase
            S_E2: case (cls_s)
                CL_RTYPE, CL_IMM, CL_LDI: last_s = 1'b1;
                CL_LD:   nxt_s = (RD_LAT == 0) ? S_E4 : S_E3;
                default: nxt_s = S_E3;
            endcase
            S_E3: case (cls_s)
                CL_LD: begin
                    nxt_s = (cnt_q == RD_LAST) ? S_E4 : S_E3;
                    cnt_d = (cnt_q == RD_LAST) ? '0 : cnt_q + CNT_ONE;
                end
                CL_ST:   nxt_s = S_E4;
                default: last_s = 1'b1;
            endcase
            S_E4: case (cls_s)
                CL_ST:   last_s = 1'b1;
                default: nxt_s = S_E5;
            endcase
            S_E5: last_s = 1'b1;
            S_DIV_WAIT: begin
                if (div_done) begin
                    nxt_s = S_E2;
                end else if (cnt_q == DIV_LAST) begin
                    nxt_s   = S_F0;
                    fault_d = 1'b1;
                end else begin
                    nxt_s = S_DIV_WAIT;
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HALT:  nxt_s = S_HALT;
            default: nxt_s = S_F0;
        endcase
        state_d = last_s ? (stop ? S_HALT : S_F0) : nxt_s;
        run_d   = (state_d != S_HALT);
    end

    // State, counter and status flops with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_F0;
            cnt_q   <= '0;
            run_q   <= 1'b1;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            fault_q <= fault_d;
        end
    end

    // Strobe decode from (state, class)
    always_comb begin
        ctl_s = '0;
        alu_s = '0;
        case (state_q)
            S_F0: begin ctl_s.pc_out = 1'b1; ctl_s.mar_in = 1'b1; ctl_s.inc_pc = 1'b1; end
            S_F1: ctl_s.read = 1'b1;
            S_F2: begin ctl_s.read = 1'b1; ctl_s.mdr_in = 1'b1; end
            S_F3: begin ctl_s.mdr_out = 1'b1; ctl_s.ir_in = 1'b1; end
            S_E0: case (cls_s)
                CL_RTYPE, CL_IMM: begin ctl_s.grb = 1'b1; ctl_s.r_out = 1'b1; ctl_s.y_in = 1'b1; end
                CL_UNARY: begin ctl_s.grb = 1'b1; ctl_s.r_out = 1'b1; ctl_s.z_in = 1'b1; alu_s = dec_alu_s; end
                CL_MUL:   begin ctl_s.gra = 1'b1; ctl_s.r_out = 1'b1; ctl_s.y_in = 1'b1; end
                CL_DIV:   begin ctl_s.gra = 1'b1; ctl_s.r_out = 1'b1; ctl_s.y_in = 1'b1; ctl_s.div_rst = 1'b1; end
                CL_LD, CL_LDI, CL_ST: begin
                    ctl_s.grb = 1'b1; ctl_s.ba_out = 1'b1; ctl_s.r_out = 1'b1; ctl_s.y_in = 1'b1;
                end
                CL_BR:  begin ctl_s.gra = 1'b1; ctl_s.r_out = 1'b1; ctl_s.con_in = 1'b1; end
                CL_JR:  begin ctl_s.gra = 1'b1; ctl_s.r_out = 1'b1; ctl_s.pc_in = 1'b1; end
                CL_JAL: begin ctl_s.pc_out = 1'b1; ctl_s.grb = 1'b1; ctl_s.r_in = 1'b1; end
                CL_IN:  begin ctl_s.inport_out = 1'b1; ctl_s.gra = 1'b1; ctl_s.r_in = 1'b1; end
                CL_OUT: begin ctl_s.gra = 1'b1; ctl_s.r_out = 1'b1; ctl_s.outport_in = 1'b1; end
                default: ctl_s = '0;
            endcase
            S_E1: case (cls_s)
                CL_RTYPE: begin ctl_s.grc = 1'b1; ctl_s.r_out = 1'b1; ctl_s.z_in = 1'b1; alu_s = dec_alu_s; end
                CL_IMM:   begin ctl_s.c_out = 1'b1; ctl_s.z_in = 1'b1; alu_s = dec_alu_s; end
                CL_UNARY: begin ctl_s.zlow_out = 1'b1; ctl_s.gra = 1'b1; ctl_s.r_in = 1'b1; end
                CL_MUL:   begin ctl_s.grb = 1'b1; ctl_s.r_out = 1'b1; ctl_s.z_in = 1'b1; alu_s = dec_alu_s; end
                CL_LD, CL_LDI, CL_ST: begin ctl_s.c_out = 1'b1; ctl_s.z_in = 1'b1; alu_s = ALU_ADD; end
                CL_BR:    begin ctl_s.pc_out = 1'b1; ctl_s.y_in = 1'b1; end
                CL_JAL:   begin ctl_s.gra = 1'b1; ctl_s.r_out = 1'b1; ctl_s.pc_in = 1'b1; end
                default:  ctl_s = '0;
            endcase
            S_E2: case (cls_s)
                CL_RTYPE, CL_IMM, CL_LDI: begin ctl_s.zlow_out = 1'b1; ctl_s.gra = 1'b1; ctl_s.r_in = 1'b1; end
                CL_MUL, CL_DIV: begin ctl_s.zlow_out = 1'b1; ctl_s.lo_in = 1'b1; end
                CL_LD, CL_ST:   begin ctl_s.zlow_out = 1'b1; ctl_s.mar_in = 1'b1; end
                CL_BR:   begin ctl_s.c_out = 1'b1; ctl_s.z_in = 1'b1; alu_s = ALU_ADD; end
                default: ctl_s = '0;
            endcase
            S_E3: case (cls_s)
                CL_MUL, CL_DIV: begin ctl_s.zhigh_out = 1'b1; ctl_s.hi_in = 1'b1; end
                CL_LD:   ctl_s.read = 1'b1;
                CL_ST:   begin ctl_s.gra = 1'b1; ctl_s.r_out = 1'b1; ctl_s.mdr_in = 1'b1; end
                CL_BR:   ctl_s.zlow_out = 1'b1;
                default: ctl_s = '0;
            endcase
            S_E4: case (cls_s)
                CL_LD:   begin ctl_s.read = 1'b1; ctl_s.mdr_in = 1'b1; end
                CL_ST:   ctl_s.write = 1'b1;
                default: ctl_s = '0;
            endcase
            S_E5: begin ctl_s.mdr_out = 1'b1; ctl_s.gra = 1'b1; ctl_s.r_in = 1'b1; end
            S_DIV_WAIT: begin
                ctl_s.grb   = 1'b1;
                ctl_s.r_out = 1'b1;
                ctl_s.z_in  = div_done;
                alu_s       = dec_alu_s;
            end
            default: ctl_s = '0;
        endcase
    end

    assign {PCout, MDRout, Zhighout, Zlowout, HIin, LOin, MDRin, MARin, Zin,
            Yin, IRin, PCin, Read, Write, IncPC, BAout, InPortout, OutPortin,
            Gra, Grb, Grc, Rin, Rout, Cout, CONin, div_rst} = clr ? '0 : ctl_s;
    assign {AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, SHRA} = clr ? '0 : alu_s;
    assign run   = run_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench: each instruction's expected per-cycle strobe sequence is
// listed from the micro-step table and compared cycle by cycle.
module tb_control_sequencer;

    localparam int RDL = 1;
    localparam int DTO = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr = 1'b1, div_done = 1'b0, stop = 1'b0;
    logic [31:0] IRdataout = 32'd0;
    logic PCout, MDRout, Zhighout, Zlowout, HIin, LOin, MDRin, MARin, Zin;
    logic Yin, IRin, PCin, Read, Write, IncPC, BAout, InPortout, OutPortin;
    logic Gra, Grb, Grc, Rin, Rout, Cout, CONin, div_rst;
    logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, SHRA;
    logic run, fault;

    control_sequencer #(.RD_LAT(RDL), .DIV_TIMEOUT(DTO)) dut (
        .clk(clk), .clr(clr), .IRdataout(IRdataout), .div_done(div_done), .stop(stop),
        .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin),
        .LOin(LOin), .MDRin(MDRin), .MARin(MARin), .Zin(Zin), .Yin(Yin), .IRin(IRin),
        .PCin(PCin), .Read(Read), .Write(Write), .IncPC(IncPC), .BAout(BAout),
        .InPortout(InPortout), .OutPortin(OutPortin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .Cout(Cout), .CONin(CONin), .div_rst(div_rst),
        .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR),
        .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT), .SHRA(SHRA),
        .run(run), .fault(fault)
    );

    logic [38:0] obs;
    assign obs = {PCout, MDRout, Zhighout, Zlowout, HIin, LOin, MDRin, MARin, Zin,
                  Yin, IRin, PCin, Read, Write, IncPC, BAout, InPortout, OutPortin,
                  Gra, Grb, Grc, Rin, Rout, Cout, CONin, div_rst,
                  AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, SHRA};

    localparam logic [38:0] M_PCO = 39'd1 << 38, M_MDRO = 39'd1 << 37, M_ZHO = 39'd1 << 36,
        M_ZLO = 39'd1 << 35, M_HII = 39'd1 << 34, M_LOI = 39'd1 << 33, M_MDRI = 39'd1 << 32,
        M_MARI = 39'd1 << 31, M_ZI = 39'd1 << 30, M_YI = 39'd1 << 29, M_IRI = 39'd1 << 28,
        M_PCI = 39'd1 << 27, M_RD = 39'd1 << 26, M_WR = 39'd1 << 25, M_INC = 39'd1 << 24,
        M_BA = 39'd1 << 23, M_INP = 39'd1 << 22, M_OUTP = 39'd1 << 21, M_GRA = 39'd1 << 20,
        M_GRB = 39'd1 << 19, M_GRC = 39'd1 << 18, M_RI = 39'd1 << 17, M_RO = 39'd1 << 16,
        M_CO = 39'd1 << 15, M_CON = 39'd1 << 14, M_DRST = 39'd1 << 13,
        M_AND = 39'd1 << 12, M_OR = 39'd1 << 11, M_ADD = 39'd1 << 10, M_SUB = 39'd1 << 9,
        M_MUL = 39'd1 << 8, M_DIV = 39'd1 << 7, M_SHR = 39'd1 << 6, M_SHL = 39'd1 << 5,
        M_ROR = 39'd1 << 4, M_ROL = 39'd1 << 3, M_NEG = 39'd1 << 2, M_NOT = 39'd1 << 1,
        M_SHRA = 39'd1;
    localparam logic [38:0] M_F0  = M_PCO | M_MARI | M_INC;
    localparam logic [38:0] M_BUS = M_PCO | M_MDRO | M_ZHO | M_ZLO | M_INP | M_CO | M_RO;

    int checks = 0, errors = 0;
    bit fault_exp = 1'b0, halted = 1'b0;
    logic [38:0] exp_q[$];
    bit dd_q[$];

    function automatic logic [38:0] alu_of(input int op);
        case (op)
            3, 12: return M_ADD;   4: return M_SUB;   5, 13: return M_AND;  6, 14: return M_OR;
            7: return M_SHR;       8: return M_SHRA;  9: return M_SHL;      10: return M_ROR;
            11: return M_ROL;      15: return M_MUL;  16: return M_DIV;     17: return M_NEG;
            18: return M_NOT;
            default: return 39'd0;
        endcase
    endfunction

    function automatic bit is_legal(input int op);
        return (op >= 0 && op <= 23) || op == 26 || op == 27;
    endfunction

    task automatic push(input logic [38:0] v, input bit dd);
        exp_q.push_back(v);
        dd_q.push_back(dd);
    endtask

    // Micro-step table: expected strobes for every cycle of one instruction.
    // d = cycles from E0 to div_done (d < 0: never arrives).
    task automatic build(input int op, input int d);
        logic [38:0] a;
        a = alu_of(op);
        exp_q.delete();
        dd_q.delete();
        push(M_F0, 1'b0);
        for (int k = 0; k < RDL; k++) push(M_RD, 1'b0);
        push(M_RD | M_MDRI, 1'b0);
        push(M_MDRO | M_IRI, 1'b0);
        if (op >= 3 && op <= 14) begin
            push(M_GRB | M_RO | M_YI, 1'b0);
            push(((op <= 11) ? (M_GRC | M_RO) : M_CO) | a | M_ZI, 1'b0);
            push(M_ZLO | M_GRA | M_RI, 1'b0);
        end else if (op == 17 || op == 18) begin
            push(M_GRB | M_RO | a | M_ZI, 1'b0);
            push(M_ZLO | M_GRA | M_RI, 1'b0);
        end else if (op == 15 || op == 16) begin
            push(M_GRA | M_RO | M_YI | ((op == 16) ? M_DRST : 39'd0), 1'b0);
            if (op == 15) begin
                push(M_GRB | M_RO | M_MUL | M_ZI, 1'b0);
            end else if (d < 0) begin
                for (int k = 0; k < DTO; k++) push(M_GRB | M_RO | M_DIV, 1'b0);
            end else begin
                for (int k = 1; k < d; k++) push(M_GRB | M_RO | M_DIV, 1'b0);
                push(M_GRB | M_RO | M_DIV | M_ZI, 1'b1);
            end
            if (!(op == 16 && d < 0)) begin
                push(M_ZLO | M_LOI, 1'b0);
                push(M_ZHO | M_HII, 1'b0);
            end
        end else if (op <= 2) begin
            push(M_GRB | M_BA | M_RO | M_YI, 1'b0);
            push(M_CO | M_ADD | M_ZI, 1'b0);
            if (op == 1) begin
                push(M_ZLO | M_GRA | M_RI, 1'b0);
            end else begin
                push(M_ZLO | M_MARI, 1'b0);
                if (op == 0) begin
                    for (int k = 0; k < RDL; k++) push(M_RD, 1'b0);
                    push(M_RD | M_MDRI, 1'b0);
                    push(M_MDRO | M_GRA | M_RI, 1'b0);
                end else begin
                    push(M_GRA | M_RO | M_MDRI, 1'b0);
                    push(M_WR, 1'b0);
                end
            end
        end else begin
            case (op)
                19: begin
                    push(M_GRA | M_RO | M_CON, 1'b0);
                    push(M_PCO | M_YI, 1'b0);
                    push(M_CO | M_ADD | M_ZI, 1'b0);
                    push(M_ZLO, 1'b0);
                end
                20: push(M_GRA | M_RO | M_PCI, 1'b0);
                21: begin
                    push(M_PCO | M_GRB | M_RI, 1'b0);
                    push(M_GRA | M_RO | M_PCI, 1'b0);
                end
                22: push(M_INP | M_GRA | M_RI, 1'b0);
                23: push(M_GRA | M_RO | M_OUTP, 1'b0);
                default: ;
            endcase
        end
    endtask

    task automatic check_fault(input string tag);
        checks++;
        if (fault !== fault_exp) begin
            errors++;
            $display("FAIL %s fault got=%b exp=%b", tag, fault, fault_exp);
        end
    endtask

    task automatic check_f0(input string tag);
        #1;
        checks++;
        if ({run, obs} !== {1'b1, M_F0}) begin
            errors++;
            $display("FAIL %s next_f0 got=%h exp=%h", tag, {run, obs}, {1'b1, M_F0});
        end
    endtask

    task automatic do_reset();
        clr = 1'b1; div_done = 1'b0; stop = 1'b0;
        #1;
        checks++;
        if (obs !== 39'd0) begin
            errors++;
            $display("FAIL clr_gate got=%h exp=%h", obs, 39'd0);
        end
        @(posedge clk); #1;
        clr = 1'b0; fault_exp = 1'b0; halted = 1'b0;
        #1;
        checks++;
        if ({run, fault, obs} !== {1'b1, 1'b0, M_F0}) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", {run, fault, obs}, {1'b1, 1'b0, M_F0});
        end
    endtask

    // Runs one instruction from F0; abort_at >= 0 asserts clr at that cycle index.
    task automatic run_instr(input int op, input int d, input bit stop_last, input int abort_at);
        int  last;
        bit  timeout, to_halt;
        logic [4:0] opc;
        opc = op[4:0];
        IRdataout = {opc, 27'($urandom)};
        timeout = (op == 16 && d < 0);
        build(op, d);
        last = exp_q.size() - 1;
        for (int i = 0; i <= last; i++) begin
            if (i == abort_at) begin
                clr = 1'b1; div_done = 1'b0; stop = 1'b0;
                #1;
                checks++;
                if (obs !== 39'd0) begin
                    errors++;
                    $display("FAIL abort_gate op=%0d cyc=%0d got=%h exp=%h", op, i, obs, 39'd0);
                end
                @(posedge clk); #1;
                clr = 1'b0; fault_exp = 1'b0;
                check_f0("abort");
                check_fault("abort");
                return;
            end
            div_done = dd_q[i];
            stop = (i == last) ? stop_last : 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({run, obs} !== {1'b1, exp_q[i]}) begin
                errors++;
                $display("FAIL strobes op=%0d cyc=%0d got=%h exp=%h", op, i, {run, obs}, {1'b1, exp_q[i]});
            end
            checks++;
            if ($countones(obs & M_BUS) > 1 || $countones(obs[12:0]) > 1) begin
                errors++;
                $display("FAIL onehot op=%0d cyc=%0d got=%h exp=%s", op, i, obs, "at most one bus/alu");
            end
            @(posedge clk); #1;
        end
        div_done = 1'b0; stop = 1'b0;
        if (!is_legal(op) || timeout) fault_exp = 1'b1;
        to_halt = (op == 27) || (stop_last && !timeout);
        if (to_halt) begin
            for (int k = 0; k < 3; k++) begin
                stop = 1'($urandom_range(0, 1));
                div_done = 1'($urandom_range(0, 1));
                #1;
                checks++;
                if ({run, obs} !== 40'd0) begin
                    errors++;
                    $display("FAIL halt op=%0d cyc=%0d got=%h exp=%h", op, k, {run, obs}, 40'd0);
                end
                @(posedge clk); #1;
            end
            stop = 1'b0; div_done = 1'b0;
            halted = 1'b1;
        end else begin
            check_f0("end");
        end
        check_fault("end");
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_add();
        run_instr(3, 0, 1'b0, -1);
        run_instr(12, 0, 1'b0, -1);
    endtask

    task automatic test_ld_st();
        run_instr(0, 0, 1'b0, -1);
        run_instr(2, 0, 1'b0, -1);
        run_instr(1, 0, 1'b0, -1);
    endtask

    task automatic test_div();
        run_instr(16, 33, 1'b0, -1);
        run_instr(16, -1, 1'b0, -1);
    endtask

    task automatic test_br_halt_stop();
        run_instr(19, 0, 1'b0, -1);
        run_instr(3, 0, 1'b1, -1);
        if (halted) do_reset();
        run_instr(27, 0, 1'b0, -1);
        if (halted) do_reset();
    endtask

    task automatic test_clr_illegal();
        run_instr(16, -1, 1'b0, 4 + RDL + 10);
        run_instr(30, 0, 1'b0, -1);
        run_instr(26, 0, 1'b1, -1);
        if (halted) do_reset();
    endtask

    task automatic test_random();
        int ops[26] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17,
                        18, 19, 20, 21, 22, 23, 26, 27};
        int bad[6] = '{24, 25, 28, 29, 30, 31};
        int op, d;
        bit sl;
        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 9) == 0) ? bad[$urandom_range(0, 5)] : ops[$urandom_range(0, 25)];
            d  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 40));
            sl = ($urandom_range(0, 7) == 0) && !(op == 16 && d < 0) && op != 27;
            run_instr(op, d, sl, -1);
            if (halted) do_reset();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=%0t exp=%s", $time, "finish before limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_ld_st();
        test_div();
        test_br_halt_stop();
        test_clr_illegal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
